// File: rtl/risc_spm_ctrl_gen_if.sv
// Control-unit <-> datapath bundle for risc_spm_ctrl_gen.
// instr_count exists only when RISC_SPM_PERF_CNT_EN is defined.
interface risc_spm_ctrl_gen_if #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned WORD_W   = 8
`ifdef RISC_SPM_PERF_CNT_EN
  , parameter int unsigned CNT_W  = 16
`endif
);
  localparam int unsigned SEL_W = $clog2(NUM_REGS);

  logic [WORD_W-1:0]   instruction;
  logic                zflag;
  logic [NUM_REGS-1:0] load_r;
  logic                load_pc;
  logic                inc_pc;
  logic                load_ir;
  logic                load_add_r;
  logic                load_reg_y;
  logic                load_reg_z;
  logic                write;
  logic [SEL_W:0]      sel_bus_1;
  logic [1:0]          sel_bus_2;
  logic                halted;
  logic                illegal;
`ifdef RISC_SPM_PERF_CNT_EN
  logic [CNT_W-1:0]    instr_count;
`endif

`ifdef RISC_SPM_PERF_CNT_EN
  modport master (
    input  instruction, zflag,
    output load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write,
    output sel_bus_1, sel_bus_2, halted, illegal, instr_count
  );
  modport slave (
    output instruction, zflag,
    input  load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write,
    input  sel_bus_1, sel_bus_2, halted, illegal, instr_count
  );
`else
  modport master (
    input  instruction, zflag,
    output load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write,
    output sel_bus_1, sel_bus_2, halted, illegal
  );
  modport slave (
    output instruction, zflag,
    input  load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write,
    input  sel_bus_1, sel_bus_2, halted, illegal
  );
`endif
endinterface

// File: rtl/risc_spm_ctrl_gen.sv
// RISC-SPM control unit: fetch/decode/execute sequencer with HLT, sticky illegal-opcode
// trap and not-taken BRZ skip. Define RISC_SPM_PERF_CNT_EN for the retired-instruction counter.
module risc_spm_ctrl_gen #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned WORD_W   = 8
`ifdef RISC_SPM_PERF_CNT_EN
  , parameter int unsigned CNT_W  = 16
`endif
) (
  input logic                 clk,
  input logic                 rst,
  risc_spm_ctrl_gen_if.master bus
);
  localparam int unsigned SEL_W = $clog2(NUM_REGS);
  localparam logic [SEL_W:0] SEL_PC = (SEL_W+1)'(NUM_REGS);

  localparam logic [1:0] SB2_ALU  = 2'd0;
  localparam logic [1:0] SB2_BUS1 = 2'd1;
  localparam logic [1:0] SB2_MEM  = 2'd2;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd9;

  if (WORD_W < 4 + 2*SEL_W || NUM_REGS < 2 || NUM_REGS > 16 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_params
    $error("risc_spm_ctrl_gen: illegal NUM_REGS/WORD_W combination");
  end

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_FET1 = 4'd1,  S_FET2 = 4'd2,  S_DEC  = 4'd3,
    S_EX1  = 4'd4,  S_RD1  = 4'd5,  S_RD2  = 4'd6,  S_WR1  = 4'd7,
    S_WR2  = 4'd8,  S_BR1  = 4'd9,  S_BR2  = 4'd10, S_HALT = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [3:0]          opcode;
  logic [SEL_W-1:0]    dst;
  logic [SEL_W-1:0]    src;
  logic [SEL_W:0]      src_sel;
  logic [NUM_REGS-1:0] dst_onehot;

  assign opcode     = bus.instruction[WORD_W-1 -: 4];
  assign dst        = bus.instruction[2*SEL_W-1 -: SEL_W];
  assign src        = bus.instruction[SEL_W-1:0];
  assign src_sel    = {1'b0, src};
  assign dst_onehot = NUM_REGS'(1) << dst;

  // State and sticky trap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = S_IDLE;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: state_d = S_FET2;
      S_FET2: state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP, OP_NOT:         state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_d = S_EX1;
          OP_RD:                  state_d = S_RD1;
          OP_WR:                  state_d = S_WR1;
          OP_BR:                  state_d = S_BR1;
          OP_BRZ:                 state_d = bus.zflag ? S_BR1 : S_FET1;
          OP_HLT:                 state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX1:  state_d = S_FET1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_FET1;
      S_WR1:  state_d = S_WR2;
      S_WR2:  state_d = S_FET1;
      S_BR1:  state_d = S_BR2;
      S_BR2:  state_d = S_FET1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state and instruction
  always_comb begin
    bus.load_r     = '0;
    bus.load_pc    = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.load_ir    = 1'b0;
    bus.load_add_r = 1'b0;
    bus.load_reg_y = 1'b0;
    bus.load_reg_z = 1'b0;
    bus.write      = 1'b0;
    bus.sel_bus_1  = '0;
    bus.sel_bus_2  = SB2_ALU;
    bus.halted     = 1'b0;
    case (state_q)
      S_FET1: begin
        bus.sel_bus_1  = SEL_PC;
        bus.sel_bus_2  = SB2_BUS1;
        bus.load_add_r = 1'b1;
      end
      S_FET2: begin
        bus.sel_bus_2 = SB2_MEM;
        bus.load_ir   = 1'b1;
        bus.inc_pc    = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.sel_bus_1  = src_sel;
            bus.sel_bus_2  = SB2_BUS1;
            bus.load_reg_y = 1'b1;
          end
          OP_NOT: begin
            bus.sel_bus_1  = src_sel;
            bus.sel_bus_2  = SB2_ALU;
            bus.load_r     = dst_onehot;
            bus.load_reg_z = 1'b1;
          end
          OP_RD, OP_WR, OP_BR: begin
            bus.sel_bus_1  = SEL_PC;
            bus.sel_bus_2  = SB2_BUS1;
            bus.load_add_r = 1'b1;
          end
          OP_BRZ: begin
            // Not taken: step PC past the address word
            if (bus.zflag) begin
              bus.sel_bus_1  = SEL_PC;
              bus.sel_bus_2  = SB2_BUS1;
              bus.load_add_r = 1'b1;
            end else begin
              bus.inc_pc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        bus.sel_bus_2  = SB2_ALU;
        bus.load_r     = dst_onehot;
        bus.load_reg_z = 1'b1;
      end
      S_RD1, S_WR1: begin
        bus.sel_bus_2  = SB2_MEM;
        bus.load_add_r = 1'b1;
        bus.inc_pc     = 1'b1;
      end
      S_RD2: begin
        bus.sel_bus_2 = SB2_MEM;
        bus.load_r    = dst_onehot;
      end
      S_WR2: begin
        bus.sel_bus_1 = src_sel;
        bus.write     = 1'b1;
      end
      S_BR1: begin
        bus.sel_bus_2  = SB2_MEM;
        bus.load_add_r = 1'b1;
      end
      S_BR2: begin
        bus.sel_bus_2 = SB2_MEM;
        bus.load_pc   = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;

`ifdef RISC_SPM_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire_c;

  // One count per instruction returning to FET1; saturating
  always_comb begin
    retire_c      = (state_d == S_FET1) &&
                    (state_q inside {S_DEC, S_EX1, S_RD2, S_WR2, S_BR2});
    instr_count_d = instr_count_q;
    if (retire_c && (instr_count_q != '1)) instr_count_d = instr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instr_count_q <= '0;
    else      instr_count_q <= instr_count_d;
  end

  assign bus.instr_count = instr_count_q;
`endif
endmodule

// File: tb/tb_risc_spm_ctrl_gen.sv
// Bench for risc_spm_ctrl_gen: a 4-register/8-bit and an 8-register/10-bit instance run in
// lockstep against a per-opcode cycle table; instr_count is checked when RISC_SPM_PERF_CNT_EN is set.
module tb_risc_spm_ctrl_gen;
  typedef struct packed {
    logic [7:0] load_r;
    logic [3:0] sel1;
    logic [1:0] sel2;
    logic       load_pc;
    logic       inc_pc;
    logic       load_ir;
    logic       load_add_r;
    logic       load_reg_y;
    logic       load_reg_z;
    logic       write;
    logic       halted;
    logic       illegal;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  risc_spm_ctrl_gen_if #(.NUM_REGS(4), .WORD_W(8))  b4();
  risc_spm_ctrl_gen_if #(.NUM_REGS(8), .WORD_W(10)) b8();

  risc_spm_ctrl_gen #(.NUM_REGS(4), .WORD_W(8))  dut4 (.clk(clk), .rst(rst), .bus(b4));
  risc_spm_ctrl_gen #(.NUM_REGS(8), .WORD_W(10)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  function automatic int nr_of(input int w);
    return (w == 0) ? 4 : 8;
  endfunction

  // Cycle count of one instruction from FET1 back to FET1
  function automatic int instr_len(input int op, input bit z);
    if (op == 0 || op == 4) return 3;
    if (op >= 1 && op <= 3) return 4;
    if (op >= 5 && op <= 7) return 5;
    return z ? 5 : 3;
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is FET1)
  function automatic cyc_t exp_cyc(input int nr, input int op, input int dst, input int src,
                                   input bit z, input int k);
    cyc_t c;
    int   d;
    int   s;
    bit   jump;
    c    = '0;
    d    = dst % nr;
    s    = src % nr;
    jump = (op == 7) || (op == 8 && z);
    case (k)
      0: begin c.sel1 = 4'(nr); c.sel2 = 2'd1; c.load_add_r = 1'b1; end
      1: begin c.sel2 = 2'd2; c.load_ir = 1'b1; c.inc_pc = 1'b1; end
      2: begin
        if (op >= 1 && op <= 3) begin
          c.sel1 = 4'(s); c.sel2 = 2'd1; c.load_reg_y = 1'b1;
        end else if (op == 4) begin
          c.sel1 = 4'(s); c.load_r = 8'(1) << d; c.load_reg_z = 1'b1;
        end else if (op == 5 || op == 6 || jump) begin
          c.sel1 = 4'(nr); c.sel2 = 2'd1; c.load_add_r = 1'b1;
        end else if (op == 8) begin
          c.inc_pc = 1'b1;
        end
      end
      3: begin
        if (op >= 1 && op <= 3) begin
          c.load_r = 8'(1) << d; c.load_reg_z = 1'b1;
        end else if (op == 5 || op == 6) begin
          c.sel2 = 2'd2; c.load_add_r = 1'b1; c.inc_pc = 1'b1;
        end else if (jump) begin
          c.sel2 = 2'd2; c.load_add_r = 1'b1;
        end
      end
      4: begin
        if (op == 5) begin
          c.sel2 = 2'd2; c.load_r = 8'(1) << d;
        end else if (op == 6) begin
          c.sel1 = 4'(s); c.write = 1'b1;
        end else if (jump) begin
          c.sel2 = 2'd2; c.load_pc = 1'b1;
        end
      end
      default: ;
    endcase
    if (op >= 9 && k >= 3) begin
      c = '0;
      c.halted = 1'b1;
    end
    if (op >= 10 && k >= 3) c.illegal = 1'b1;
    return c;
  endfunction

  function automatic cyc_t obs(input int w);
    cyc_t c;
    c = '0;
    if (w == 0) begin
      c.load_r = 8'(b4.load_r);   c.sel1 = 4'(b4.sel_bus_1); c.sel2 = b4.sel_bus_2;
      c.load_pc = b4.load_pc;     c.inc_pc = b4.inc_pc;      c.load_ir = b4.load_ir;
      c.load_add_r = b4.load_add_r; c.load_reg_y = b4.load_reg_y;
      c.load_reg_z = b4.load_reg_z; c.write = b4.write;
      c.halted = b4.halted;       c.illegal = b4.illegal;
    end else begin
      c.load_r = b8.load_r;       c.sel1 = b8.sel_bus_1;     c.sel2 = b8.sel_bus_2;
      c.load_pc = b8.load_pc;     c.inc_pc = b8.inc_pc;      c.load_ir = b8.load_ir;
      c.load_add_r = b8.load_add_r; c.load_reg_y = b8.load_reg_y;
      c.load_reg_z = b8.load_reg_z; c.write = b8.write;
      c.halted = b8.halted;       c.illegal = b8.illegal;
    end
    return c;
  endfunction

`ifdef RISC_SPM_PERF_CNT_EN
  function automatic logic [15:0] cnt_of(input int w);
    return (w == 0) ? b4.instr_count : b8.instr_count;
  endfunction
`endif

  task automatic set_instr(input int op, input int dst, input int src, input bit z);
    b4.instruction = {4'(op), 2'(dst), 2'(src)};
    b8.instruction = {4'(op), 3'(dst), 3'(src)};
    b4.zflag = z;
    b8.zflag = z;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Deassert reset away from the edge; returns sampling inside FET1
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    cyc_t got;
    rst = 1'b0;
    set_instr(0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      got = obs(w);
      n_vec++;
      if (got !== cyc_t'(0)) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got %h want %h", w, got, cyc_t'(0));
      end
`ifdef RISC_SPM_PERF_CNT_EN
      n_vec++;
      if (cnt_of(w) !== 16'd0) begin
        n_err++;
        $display("FAIL reset_count dut%0d: got %0d want 0", w, cnt_of(w));
      end
`endif
    end
    exp_count = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      got = obs(w);
      n_vec++;
      if (got !== cyc_t'(0)) begin
        n_err++;
        $display("FAIL idle_state dut%0d: got %h want %h", w, got, cyc_t'(0));
      end
    end
    step();
  endtask

  task automatic test_directed();
    int   tbl [10][4] = '{'{1,2,1,0}, '{5,3,0,0}, '{8,0,0,0}, '{8,0,0,1}, '{4,5,6,0},
                          '{0,7,7,1}, '{6,1,3,0}, '{7,0,0,0}, '{2,6,5,0}, '{3,3,4,1}};
    cyc_t got, want;
    for (int i = 0; i < 10; i++) begin
      set_instr(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3] != 0);
`ifdef RISC_SPM_PERF_CNT_EN
      for (int w = 0; w < 2; w++) begin
        n_vec++;
        if (cnt_of(w) !== 16'(exp_count)) begin
          n_err++;
          $display("FAIL dir_count dut%0d i%0d: got %0d want %0d", w, i, cnt_of(w), exp_count);
        end
      end
`endif
      for (int k = 0; k < instr_len(tbl[i][0], tbl[i][3] != 0); k++) begin
        for (int w = 0; w < 2; w++) begin
          got  = obs(w);
          want = exp_cyc(nr_of(w), tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3] != 0, k);
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL dir dut%0d op%0d k%0d: got %h want %h", w, tbl[i][0], k, got, want);
          end
        end
        step();
      end
      if (exp_count < 65535) exp_count++;
    end
  endtask

  task automatic test_random();
    int   op, dst, src;
    bit   z;
    cyc_t got, want;
    for (int i = 0; i < 150; i++) begin
      op  = int'($urandom_range(0, 8));
      dst = int'($urandom_range(0, 7));
      src = int'($urandom_range(0, 7));
      z   = 1'($urandom);
      set_instr(op, dst, src, z);
`ifdef RISC_SPM_PERF_CNT_EN
      for (int w = 0; w < 2; w++) begin
        n_vec++;
        if (cnt_of(w) !== 16'(exp_count)) begin
          n_err++;
          $display("FAIL rnd_count dut%0d i%0d: got %0d want %0d", w, i, cnt_of(w), exp_count);
        end
      end
`endif
      for (int k = 0; k < instr_len(op, z); k++) begin
        for (int w = 0; w < 2; w++) begin
          got  = obs(w);
          want = exp_cyc(nr_of(w), op, dst, src, z, k);
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL rnd dut%0d op%0d d%0d s%0d z%0d k%0d: got %h want %h",
                     w, op, dst, src, z, k, got, want);
          end
        end
        step();
      end
      if (exp_count < 65535) exp_count++;
    end
  endtask

  // Reset asserted in WR1, then NOP/ADD/WR must leave the counter at 3
  task automatic test_reset_mid();
    int   tbl [3][3] = '{'{0,0,0}, '{1,2,1}, '{6,1,2}};
    cyc_t got, want;
    set_instr(6, 2, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 2; w++) begin
        got  = obs(w);
        want = exp_cyc(nr_of(w), 6, 2, 3, 1'b0, k);
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL mid_pre dut%0d k%0d: got %h want %h", w, k, got, want);
        end
      end
      if (k < 3) step();
    end
    rst = 1'b0;
    #1;
    exp_count = 0;
    for (int w = 0; w < 2; w++) begin
      got = obs(w);
      n_vec++;
      if (got !== cyc_t'(0)) begin
        n_err++;
        $display("FAIL mid_reset dut%0d: got %h want %h", w, got, cyc_t'(0));
      end
    end
    release_rst();
    for (int i = 0; i < 3; i++) begin
      set_instr(tbl[i][0], tbl[i][1], tbl[i][2], 1'b0);
      for (int k = 0; k < instr_len(tbl[i][0], 1'b0); k++) begin
        for (int w = 0; w < 2; w++) begin
          got  = obs(w);
          want = exp_cyc(nr_of(w), tbl[i][0], tbl[i][1], tbl[i][2], 1'b0, k);
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL mid_post dut%0d op%0d k%0d: got %h want %h", w, tbl[i][0], k, got, want);
          end
        end
        step();
      end
      exp_count++;
    end
`ifdef RISC_SPM_PERF_CNT_EN
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (cnt_of(w) !== 16'(exp_count)) begin
        n_err++;
        $display("FAIL mid_count dut%0d: got %0d want %0d", w, cnt_of(w), exp_count);
      end
    end
`endif
  endtask

  // HLT and illegal opcodes: park in HALT, no strobes, cleared by reset
  task automatic test_halt();
    int   ops [3];
    cyc_t got, want;
    ops[0] = 9;
    ops[1] = 10;
    ops[2] = int'($urandom_range(11, 15));
    for (int i = 0; i < 3; i++) begin
      set_instr(ops[i], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom));
      for (int k = 0; k < 23; k++) begin
        for (int w = 0; w < 2; w++) begin
          got  = obs(w);
          want = exp_cyc(nr_of(w), ops[i], 0, 0, 1'b0, k);
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL halt dut%0d op%0d k%0d: got %h want %h", w, ops[i], k, got, want);
          end
`ifdef RISC_SPM_PERF_CNT_EN
          if (k == 22) begin
            n_vec++;
            if (cnt_of(w) !== 16'(exp_count)) begin
              n_err++;
              $display("FAIL halt_count dut%0d op%0d: got %0d want %0d", w, ops[i], cnt_of(w), exp_count);
            end
          end
`endif
        end
        if (k < 22) step();
      end
      rst = 1'b0;
      #1;
      exp_count = 0;
      for (int w = 0; w < 2; w++) begin
        got = obs(w);
        n_vec++;
        if (got !== cyc_t'(0)) begin
          n_err++;
          $display("FAIL halt_clear dut%0d op%0d: got %h want %h", w, ops[i], got, cyc_t'(0));
        end
      end
      release_rst();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
